// File: rtl/tulip_prog_pkg.sv
// Shared types for the coefficient-programming initiator.
//   prog_state_t     : sequencer states
//   C_BEAT_CNT_WIDTH : width of the per-sequence beat counter
package tulip_prog_pkg;

   localparam int unsigned C_BEAT_CNT_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE,
      STREAM,
      WAIT_DONE,
      DONE,
      ERROR
   } prog_state_t;

endpackage

// File: rtl/sync_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, reset                 : clock, synchronous active-high clear
//   din, din_valid, din_ready  : write side; din_ready = !full once out of reset
//   dout, dout_valid, dout_ready : read side; dout shows the head word, 0 when empty
//   level                      : current occupancy (0..2**DEPTH_LOG2)
module sync_fwft_fifo #(
   parameter int unsigned DWIDTH     = 24,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DWIDTH-1:0]     din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [DWIDTH-1:0]     dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
   localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
   localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);

   logic [DWIDTH-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  armed;
   logic                  full;
   logic                  empty;
   logic                  wr_en;
   logic                  rd_en;

   assign full       = (level == LVL_FULL);
   assign empty      = (level == '0);
   // armed keeps din_ready low while in reset and for the reset edge itself
   assign din_ready  = armed & !full;
   assign dout_valid = !empty;
   assign dout       = empty ? '0 : mem[rd_ptr];
   assign wr_en      = din_valid & din_ready;
   assign rd_en      = dout_valid & dout_ready;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         armed  <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         armed <= 1'b1;
         if (wr_en)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_en, rd_en})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/coef_prog_streamer.sv
// Coefficient-programming initiator: buffers control-plane words in a FIFO and,
// on start, streams G_NUM_COEFS of them to a consumer, then waits for its done flag.
//   clk, reset, enable           : clock, sync active-high reset, enable=0 also resets
//   start                        : one-cycle pulse, arms a sequence from IDLE/DONE/ERROR
//   wr_data, wr_valid, wr_ready  : control-plane write port into the FIFO
//   prog_dout, prog_dout_valid, prog_dout_ready : stream to the consumer
//   prog_done                    : consumer finished programming
//   busy, complete, error        : status (complete/error sticky until next start)
//   beat_count, fifo_level       : words accepted this sequence, FIFO occupancy
module coef_prog_streamer
   import tulip_prog_pkg::*;
#(
   parameter int unsigned G_DWIDTH          = 24,
   parameter int unsigned G_NUM_COEFS       = 129,
   parameter int unsigned G_FIFO_DEPTH_LOG2 = 4,
   parameter int unsigned G_DONE_TIMEOUT    = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          start,
   input  logic [G_DWIDTH-1:0]           wr_data,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   output logic [G_DWIDTH-1:0]           prog_dout,
   output logic                          prog_dout_valid,
   input  logic                          prog_dout_ready,
   input  logic                          prog_done,
   output logic                          busy,
   output logic                          complete,
   output logic                          error,
   output logic [C_BEAT_CNT_WIDTH-1:0]   beat_count,
   output logic [G_FIFO_DEPTH_LOG2:0]    fifo_level
);

   localparam int unsigned TW = $clog2(G_DONE_TIMEOUT + 1);
   localparam logic [C_BEAT_CNT_WIDTH-1:0] NUM      = C_BEAT_CNT_WIDTH'(G_NUM_COEFS);
   localparam logic [C_BEAT_CNT_WIDTH-1:0] BEAT_ONE = 1;
   localparam logic [TW-1:0]               TO_LAST  = TW'(G_DONE_TIMEOUT - 1);
   localparam logic [TW-1:0]               TO_ONE   = 1;

   prog_state_t   state;
   logic [TW-1:0] to_cnt;
   logic          srst;
   logic          beats_left;
   logic          stream_on;
   logic          fifo_valid;
   logic          xfer;

   assign srst       = reset | !enable;
   assign beats_left = (beat_count < NUM);
   assign stream_on  = (state == STREAM) & beats_left;
   assign prog_dout_valid = stream_on & fifo_valid;
   assign xfer       = prog_dout_valid & prog_dout_ready;
   assign busy       = (state == STREAM) | (state == WAIT_DONE);

   // The FIFO pops only when the consumer actually takes a beat.
   sync_fwft_fifo #(
      .DWIDTH     (G_DWIDTH),
      .DEPTH_LOG2 (G_FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk        (clk),
      .reset      (srst),
      .din        (wr_data),
      .din_valid  (wr_valid),
      .din_ready  (wr_ready),
      .dout       (prog_dout),
      .dout_valid (fifo_valid),
      .dout_ready (stream_on & prog_dout_ready),
      .level      (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (srst) begin
         state      <= IDLE;
         beat_count <= '0;
         to_cnt     <= '0;
         complete   <= 1'b0;
         error      <= 1'b0;
      end else begin
         if (xfer)
            beat_count <= beat_count + BEAT_ONE;
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state      <= STREAM;
                  beat_count <= '0;
                  to_cnt     <= '0;
                  complete   <= 1'b0;
                  error      <= 1'b0;
               end
            end
            STREAM: begin
               // done before all beats were sent means the consumer is out of step
               if (prog_done && beats_left) begin
                  state <= ERROR;
                  error <= 1'b1;
               end else if (!beats_left) begin
                  state  <= WAIT_DONE;
                  to_cnt <= '0;
               end
            end
            WAIT_DONE: begin
               // prog_done takes priority over an expiring timeout
               if (prog_done) begin
                  state    <= DONE;
                  complete <= 1'b1;
               end else if (to_cnt == TO_LAST) begin
                  state <= ERROR;
                  error <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TO_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_coef_prog_streamer.sv
// Self-checking bench for coef_prog_streamer.
//   dut_a: 16-bit words, 3 coefficients, timeout 8 -- table-driven vectors
//   dut_b: 24-bit words, 129 coefficients -- full FIFO, backpressure, reset mid-stream
module tb_coef_prog_streamer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- dut_a ----------------
   logic        a_reset, a_enable, a_start, a_wr_valid, a_wr_ready;
   logic [15:0] a_wr_data, a_dout, a_beat;
   logic        a_valid, a_ready, a_done, a_busy, a_complete, a_error;
   logic [4:0]  a_level;

   coef_prog_streamer #(
      .G_DWIDTH          (16),
      .G_NUM_COEFS       (3),
      .G_FIFO_DEPTH_LOG2 (4),
      .G_DONE_TIMEOUT    (8)
   ) dut_a (
      .clk             (clk),
      .reset           (a_reset),
      .enable          (a_enable),
      .start           (a_start),
      .wr_data         (a_wr_data),
      .wr_valid        (a_wr_valid),
      .wr_ready        (a_wr_ready),
      .prog_dout       (a_dout),
      .prog_dout_valid (a_valid),
      .prog_dout_ready (a_ready),
      .prog_done       (a_done),
      .busy            (a_busy),
      .complete        (a_complete),
      .error           (a_error),
      .beat_count      (a_beat),
      .fifo_level      (a_level)
   );

   // ---------------- dut_b ----------------
   logic        b_reset, b_enable, b_start, b_wr_valid, b_wr_ready;
   logic [23:0] b_wr_data, b_dout;
   logic [15:0] b_beat;
   logic        b_valid, b_ready, b_done, b_busy, b_complete, b_error;
   logic [4:0]  b_level;

   coef_prog_streamer #(
      .G_DWIDTH          (24),
      .G_NUM_COEFS       (129),
      .G_FIFO_DEPTH_LOG2 (4),
      .G_DONE_TIMEOUT    (1024)
   ) dut_b (
      .clk             (clk),
      .reset           (b_reset),
      .enable          (b_enable),
      .start           (b_start),
      .wr_data         (b_wr_data),
      .wr_valid        (b_wr_valid),
      .wr_ready        (b_wr_ready),
      .prog_dout       (b_dout),
      .prog_dout_valid (b_valid),
      .prog_dout_ready (b_ready),
      .prog_done       (b_done),
      .busy            (b_busy),
      .complete        (b_complete),
      .error           (b_error),
      .beat_count      (b_beat),
      .fifo_level      (b_level)
   );

   typedef struct {
      logic        rst, en, st, wv;
      logic [15:0] wd;
      logic        rdy, dn;
      logic        wr_rdy, vld;
      logic [15:0] dout;
      logic        busy, cmp, err;
      logic [15:0] beat;
      logic [4:0]  lvl;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic rst, input logic en, input logic st, input logic wv, input logic [15:0] wd,
      input logic rdy, input logic dn,
      input logic wr_rdy, input logic vld, input logic [15:0] dout, input logic busy,
      input logic cmp, input logic err, input logic [15:0] beat, input logic [4:0] lvl);
      vec_t v;
      v.rst = rst; v.en = en; v.st = st; v.wv = wv; v.wd = wd; v.rdy = rdy; v.dn = dn;
      v.wr_rdy = wr_rdy; v.vld = vld; v.dout = dout; v.busy = busy;
      v.cmp = cmp; v.err = err; v.beat = beat; v.lvl = lvl;
      return v;
   endfunction

   function automatic logic [23:0] word(input int unsigned i);
      return 24'hA50000 | 24'(i);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned k;
      int unsigned xfers;
      int unsigned expn;
      int unsigned cyc;
      logic        rdy_t;
      logic        stall;
      logic [23:0] stall_data;
      logic        accepted;

      a_reset = 1'b1; a_enable = 1'b1; a_start = 1'b0; a_wr_valid = 1'b0;
      a_wr_data = '0; a_ready = 1'b0; a_done = 1'b0;
      b_reset = 1'b1; b_enable = 1'b1; b_start = 1'b0; b_wr_valid = 1'b0;
      b_wr_data = '0; b_ready = 1'b0; b_done = 1'b0;

      //                 rst en st wv wd  rdy dn | wrr vld dout busy cmp err beat lvl
      vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0,   0, 0, 0,  0, 0, 0, 0, 0)); // reset
      vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0,   1, 0, 0,  0, 0, 0, 0, 0)); // wr_ready rises
      vecs.push_back(mk(0, 1, 0, 1, 3,  0, 0,   1, 0, 3,  0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 1, 0, 1, 5,  0, 0,   1, 0, 3,  0, 0, 0, 0, 2));
      vecs.push_back(mk(0, 1, 0, 1, 7,  0, 0,   1, 0, 3,  0, 0, 0, 0, 3));
      vecs.push_back(mk(0, 1, 1, 0, 0,  1, 0,   1, 1, 3,  1, 0, 0, 0, 3)); // start
      vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0,   1, 1, 5,  1, 0, 0, 1, 2)); // beat 3
      vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0,   1, 1, 7,  1, 0, 0, 2, 1)); // beat 5
      vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0,   1, 0, 0,  1, 0, 0, 3, 0)); // beat 7
      vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0,   1, 0, 0,  1, 0, 0, 3, 0)); // -> WAIT_DONE
      vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0,   1, 0, 0,  1, 0, 0, 3, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,  1, 1,   1, 0, 0,  0, 1, 0, 3, 0)); // done -> complete
      vecs.push_back(mk(0, 1, 1, 1, 9,  0, 0,   1, 1, 9,  1, 0, 0, 0, 1)); // re-arm + write
      vecs.push_back(mk(0, 1, 0, 1, 11, 0, 0,   1, 1, 9,  1, 0, 0, 0, 2)); // stall holds
      vecs.push_back(mk(0, 1, 0, 1, 13, 1, 0,   1, 1, 11, 1, 0, 0, 1, 2)); // rd+wr same cycle
      vecs.push_back(mk(0, 1, 1, 0, 0,  1, 0,   1, 1, 13, 1, 0, 0, 2, 1)); // start ignored
      vecs.push_back(mk(0, 1, 0, 0, 0,  0, 1,   1, 0, 13, 0, 0, 1, 2, 1)); // early done
      vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0,   1, 1, 13, 1, 0, 0, 0, 1)); // re-arm from ERROR
      vecs.push_back(mk(0, 1, 0, 1, 15, 1, 0,   1, 1, 15, 1, 0, 0, 1, 1));
      vecs.push_back(mk(0, 1, 0, 1, 17, 1, 0,   1, 1, 17, 1, 0, 0, 2, 1));
      vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0,   1, 0, 0,  1, 0, 0, 3, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0,   1, 0, 0,  1, 0, 0, 3, 0)); // -> WAIT_DONE
      for (int i = 0; i < 7; i++)                                         // 7 waiting cycles
         vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 3, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0,   1, 0, 0,  0, 0, 1, 3, 0)); // 8th -> timeout
      vecs.push_back(mk(0, 1, 1, 0, 0,  0, 0,   1, 0, 0,  1, 0, 0, 0, 0)); // start clears error
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0,   0, 0, 0,  0, 0, 0, 0, 0)); // enable=0
      vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0,   1, 0, 0,  0, 0, 0, 0, 0));

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         a_reset = vecs[i].rst; a_enable = vecs[i].en; a_start = vecs[i].st;
         a_wr_valid = vecs[i].wv; a_wr_data = vecs[i].wd;
         a_ready = vecs[i].rdy; a_done = vecs[i].dn;
         @(negedge clk);
         check($sformatf("a[%0d] wr_ready", i), 32'(a_wr_ready), 32'(vecs[i].wr_rdy));
         check($sformatf("a[%0d] valid", i),    32'(a_valid),    32'(vecs[i].vld));
         check($sformatf("a[%0d] dout", i),     32'(a_dout),     32'(vecs[i].dout));
         check($sformatf("a[%0d] busy", i),     32'(a_busy),     32'(vecs[i].busy));
         check($sformatf("a[%0d] complete", i), 32'(a_complete), 32'(vecs[i].cmp));
         check($sformatf("a[%0d] error", i),    32'(a_error),    32'(vecs[i].err));
         check($sformatf("a[%0d] beat", i),     32'(a_beat),     32'(vecs[i].beat));
         check($sformatf("a[%0d] level", i),    32'(a_level),    32'(vecs[i].lvl));
      end

      // ---- dut_b: reset, then fill the FIFO without a start ----
      @(negedge clk);
      check("b reset wr_ready", 32'(b_wr_ready), 0);
      b_reset = 1'b0;
      @(negedge clk);
      check("b wr_ready after reset", 32'(b_wr_ready), 1);

      k = 1;
      repeat (20) begin
         b_wr_valid = 1'b1;
         b_wr_data  = word(k);
         accepted   = b_wr_ready;
         @(negedge clk);
         if (accepted) k++;
      end
      check("b full level", 32'(b_level), 16);
      check("b full wr_ready", 32'(b_wr_ready), 0);
      check("b full no valid in IDLE", 32'(b_valid), 0);
      check("b full head word", 32'(b_dout), 32'(word(1)));

      // ---- start with ready toggling 1010..., producer keeps writing ----
      b_start = 1'b1;
      xfers = 0; expn = 1; cyc = 0; rdy_t = 1'b1; stall = 1'b0; stall_data = '0;
      while (xfers < 129 && cyc < 2000) begin
         if (stall) begin
            check("b stall valid held", 32'(b_valid), 1);
            check("b stall data held", 32'(b_dout), 32'(stall_data));
         end
         b_ready = rdy_t;
         if (k <= 129) begin
            b_wr_valid = 1'b1;
            b_wr_data  = word(k);
         end else begin
            b_wr_valid = 1'b0;
         end
         stall      = b_valid && !rdy_t;
         stall_data = b_dout;
         if (b_valid && rdy_t) begin
            check($sformatf("b beat %0d data", expn), 32'(b_dout), 32'(word(expn)));
            expn++;
            xfers++;
         end
         if (b_wr_valid && b_wr_ready) k++;
         @(negedge clk);
         b_start = 1'b0;
         rdy_t   = !rdy_t;
         cyc++;
      end
      check("b transfer count within budget", xfers, 129);

      b_ready = 1'b1;
      b_wr_valid = 1'b0;
      repeat (5) begin
         check("b no valid after last beat", 32'(b_valid), 0);
         @(negedge clk);
      end
      check("b beat_count final", 32'(b_beat), 129);
      check("b busy in WAIT_DONE", 32'(b_busy), 1);
      check("b level drained", 32'(b_level), 0);

      b_done = 1'b1;
      @(negedge clk);
      b_done = 1'b0;
      check("b complete", 32'(b_complete), 1);
      check("b not busy after done", 32'(b_busy), 0);

      // ---- reset in the middle of a sequence, after beat 5 ----
      b_ready = 1'b0;
      k = 1;
      repeat (8) begin
         b_wr_valid = 1'b1;
         b_wr_data  = word(k);
         @(negedge clk);
         k++;
      end
      b_wr_valid = 1'b0;
      check("b level before restart", 32'(b_level), 8);
      b_start = 1'b1;
      b_ready = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      check("b restart clears complete", 32'(b_complete), 0);
      check("b restart busy", 32'(b_busy), 1);
      cyc = 0;
      while (b_beat != 16'd5 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("b reached beat 5", 32'(b_beat), 5);
      check("b head after beat 5", 32'(b_dout), 32'(word(6)));
      b_reset = 1'b1;
      @(negedge clk);
      check("b rst wr_ready", 32'(b_wr_ready), 0);
      check("b rst valid",    32'(b_valid),    0);
      check("b rst dout",     32'(b_dout),     0);
      check("b rst busy",     32'(b_busy),     0);
      check("b rst complete", 32'(b_complete), 0);
      check("b rst error",    32'(b_error),    0);
      check("b rst beat",     32'(b_beat),     0);
      check("b rst level",    32'(b_level),    0);
      b_reset = 1'b0;
      @(negedge clk);
      check("b post-rst wr_ready", 32'(b_wr_ready), 1);
      check("b post-rst valid",    32'(b_valid),    0);
      check("b post-rst level",    32'(b_level),    0);
      check("b post-rst busy",     32'(b_busy),     0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/coef_prog_streamer.md
Name: coef_prog_streamer

Overview:
- Initiator side of the valid/ready/done coefficient-programming interface used by the DSP chain's LUT, user FIR and reverb blocks.
- Buffers coefficient words written by the control plane (register bank / CPU path) in a small FIFO.
- On `start`, streams exactly G_NUM_COEFS words to the consumer's `*_prog_din` port, then waits for the consumer's done flag and reports `complete` or `error`.
- One instance sits between the register bank and each programmable DSP stage.

Parameters:
- G_DWIDTH, 24: coefficient word width; 16 for FIR/reverb taps, 24 for the LUT.
- G_NUM_COEFS, 129: words per programming sequence; range 1..65535.
- G_FIFO_DEPTH_LOG2, 4: write FIFO depth is 2**G_FIFO_DEPTH_LOG2.
- G_DONE_TIMEOUT, 1024: cycles allowed in WAIT_DONE before error; minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  0 acts as reset (codebase convention)
- start  in  1  one-cycle pulse; begins a programming sequence
- wr_data  in  G_DWIDTH  coefficient word from control plane
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  FIFO not full
- prog_dout  out  G_DWIDTH  word to consumer `*_prog_din`
- prog_dout_valid  out  1  to consumer `*_prog_din_valid`
- prog_dout_ready  in  1  from consumer `*_prog_din_ready`
- prog_done  in  1  from consumer `*_prog_done`
- busy  out  1  state is STREAM or WAIT_DONE
- complete  out  1  sticky; sequence finished successfully
- error  out  1  sticky; sequence failed
- beat_count  out  16  words accepted by consumer this sequence
- fifo_level  out  G_FIFO_DEPTH_LOG2+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high. `reset=1` or `enable=0` on a rising edge empties the FIFO, forces IDLE and clears every output register. Reset values: wr_ready=0, prog_dout_valid=0, busy=0, complete=0, error=0, beat_count=0, fifo_level=0, prog_dout=0. wr_ready rises the cycle after reset/enable deasserts. Reset mid-sequence abandons it; no further valid beats.
- FIFO:
  - First-word-fall-through. `wr_ready = !full`.
  - A write happens when wr_valid & wr_ready, in any state.
  - A word written into an empty FIFO at edge t appears on prog_dout after edge t and is eligible for transfer at edge t+1.
  - When full, no write is accepted even if a read happens in the same cycle. wr_ready returns high the cycle after a read.
  - Read and write in the same cycle leave fifo_level unchanged. Pointers wrap modulo depth.
- Handshake:
  - `prog_dout_valid = (state==STREAM) & !empty & (beat_count < G_NUM_COEFS)`.
  - A transfer occurs on valid & prog_dout_ready. Each transfer pops the FIFO and increments beat_count.
  - prog_dout and valid stay stable while valid=1 and ready=0. Valid never drops without a transfer, except on reset.
- FSM states:
  - IDLE: on start, clear beat_count, complete, error and go to STREAM.
  - STREAM: transfer words as above. The cycle after beat_count reaches G_NUM_COEFS, go to WAIT_DONE with the timeout counter cleared. prog_done=1 while beat_count < G_NUM_COEFS goes to ERROR (consumer already programmed or short). FIFO underrun just stalls; no timeout in STREAM.
  - WAIT_DONE: prog_done=1 goes to DONE. When the timeout counter reaches G_DONE_TIMEOUT, go to ERROR. If both fire in the same cycle, prog_done wins.
  - DONE: complete=1. On start, re-arm exactly as from IDLE.
  - ERROR: error=1. On start, re-arm exactly as from IDLE.
- Residual words: words left in the FIFO after a sequence stay buffered for the next sequence.
- Ignored starts: start in STREAM or WAIT_DONE is ignored.
- Latency: first transfer no earlier than 1 cycle after start; it occurs on the edge after start if the FIFO is non-empty and ready=1. Throughput is 1 word/cycle.

Decomposition:
- Package `tulip_prog_pkg`:
  - enum `prog_state_t` {IDLE, STREAM, WAIT_DONE, DONE, ERROR}
  - constant C_BEAT_CNT_WIDTH=16
- One sub-module `sync_fwft_fifo`: parameters DWIDTH and DEPTH_LOG2; ports din/valid/ready, dout/valid/ready, level. Reusable elsewhere in the codebase.

Test Plan:
- G_NUM_COEFS=3: write 3, 5, 7, pulse start, ready held 1 → prog_dout 3, 5, 7 on three consecutive edges, beat_count=3. Then drive prog_done=1 two cycles later → complete=1, busy=0.
- Backpressure: 129 words, ready toggled 1010…, start → exactly 129 transfers in order, data stable during ready=0 cycles, no valid after beat 129.
- Full FIFO (depth 16): 20 writes with no start → wr_ready=0 after 16, fifo_level=16. Start with ready=1 → words 1..16 delivered, writes 17..20 then accepted.
- Timeout: G_DONE_TIMEOUT=8, all words delivered, prog_done held 0 → error=1 after 8 cycles in WAIT_DONE. Start re-arms and clears error.
- Early done: prog_done=1 after beat 2 of 3 → error=1, prog_dout_valid=0. A start pulse during STREAM in another run has no effect.
- Reset mid-STREAM after beat 5 → next cycle all outputs at reset values, FIFO empty, no valid.
